// File: rtl/xc_malu_mul_ctrl.sv
// Sequencer for the iterative shift-add / carry-less multiply step datapath.
// Latency: 33 cycles from accepted request to ready pulse (1 cycle on the zero-operand shortcut).
// Backpressure: one op in flight; requester holds valid until ready; flush or dropped valid aborts.
module xc_malu_mul_ctrl #(
    parameter int FAST_ZERO = 1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        valid,
    input  logic        flush,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        op_mul,
    input  logic        op_mulh,
    input  logic        op_mulhu,
    input  logic        op_mulhsu,
    input  logic        op_clmul,
    input  logic        op_clmulh,
    output logic        ready,
    output logic [31:0] result,
    output logic [31:0] step_rs1,
    output logic [31:0] step_rs2,
    output logic [5:0]  step_count,
    output logic [63:0] step_acc,
    output logic [31:0] step_arg_0,
    output logic        step_carryless,
    output logic        step_lhs_sign,
    output logic        step_rhs_sign,
    input  logic [63:0] step_n_acc,
    input  logic [31:0] step_n_arg_0,
    input  logic        step_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_COUNT = 6'd32;

    state_t      state;
    state_t      n_state;

    logic [31:0] lat_rs1;
    logic [31:0] lat_rs2;
    logic [63:0] acc;
    logic [31:0] arg_0;
    logic [5:0]  count;

    // Latched op decode, one bit per supported operation.
    logic        lat_mul;
    logic        lat_mulh;
    logic        lat_mulhu;
    logic        lat_mulhsu;
    logic        lat_clmul;
    logic        lat_clmulh;

    logic [5:0]  op_vec;
    logic        op_onehot;
    logic        start;
    logic        zero_operand;
    logic        take_shortcut;
    logic        abort_run;
    logic        step_en;
    logic        hi_select;

    // Request decode: exactly one op bit must be set for the request to be taken.
    always_comb begin
        op_vec        = {op_clmulh, op_clmul, op_mulhsu, op_mulhu, op_mulh, op_mul};
        op_onehot     = (op_vec != 6'd0) && ((op_vec & (op_vec - 6'd1)) == 6'd0);
        start         = valid && !flush && op_onehot;
        zero_operand  = (rs1 == 32'd0) || (rs2 == 32'd0);
        take_shortcut = (FAST_ZERO != 0) && zero_operand;
        // Dropping valid mid-iteration is the requester walking away from the op.
        abort_run     = flush || !valid;
        step_en       = (state == RUN) && !abort_run && !step_ready;
    end

    // State register.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state <= IDLE;
        end else begin
            state <= n_state;
        end
    end

    // Next-state logic; flush wins over every other transition.
    always_comb begin
        n_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    n_state = take_shortcut ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_run) begin
                    n_state = IDLE;
                end else if (step_ready) begin
                    n_state = DONE;
                end
            end
            DONE: begin
                n_state = IDLE;
            end
            default: begin
                n_state = IDLE;
            end
        endcase
    end

    // Operand and op capture at acceptance; ignored for the rest of the op.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            lat_rs1    <= 32'd0;
            lat_rs2    <= 32'd0;
            lat_mul    <= 1'b0;
            lat_mulh   <= 1'b0;
            lat_mulhu  <= 1'b0;
            lat_mulhsu <= 1'b0;
            lat_clmul  <= 1'b0;
            lat_clmulh <= 1'b0;
        end else if ((state == IDLE) && start) begin
            lat_rs1    <= rs1;
            lat_rs2    <= rs2;
            lat_mul    <= op_mul;
            lat_mulh   <= op_mulh;
            lat_mulhu  <= op_mulhu;
            lat_mulhsu <= op_mulhsu;
            lat_clmul  <= op_clmul;
            lat_clmulh <= op_clmulh;
        end
    end

    // Accumulator, multiplier shift register and step counter.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            acc   <= 64'd0;
            arg_0 <= 32'd0;
            count <= 6'd0;
        end else if ((state == IDLE) && start) begin
            // The shortcut also lands here: a zero accumulator is the zero result.
            acc   <= 64'd0;
            arg_0 <= rs2;
            count <= 6'd0;
        end else if (step_en) begin
            acc   <= step_n_acc;
            arg_0 <= step_n_arg_0;
            // Saturate rather than wrap if the datapath is ever late with step_ready.
            if (count != LAST_COUNT) begin
                count <= count + 6'd1;
            end
        end
    end

    // Step datapath controls and the result mux.
    always_comb begin
        hi_select      = lat_mulh || lat_mulhu || lat_mulhsu || lat_clmulh;
        step_rs1       = lat_rs1;
        step_rs2       = lat_rs2;
        step_count     = count;
        step_acc       = acc;
        step_arg_0     = arg_0;
        step_carryless = lat_clmul || lat_clmulh;
        step_lhs_sign  = lat_mulh || lat_mulhsu;
        step_rhs_sign  = lat_mulh;
        // A flush arriving in DONE suppresses the pulse for that op.
        ready          = (state == DONE) && !flush;
        result         = 32'd0;
        if (ready) begin
            result = hi_select ? acc[63:32] : acc[31:0];
        end
    end

    // lat_mul has no control role of its own: a latched op that is not any of the
    // others selects the low product word, which is the default above.
    logic unused_lat_mul;
    assign unused_lat_mul = lat_mul;

endmodule
